// File: rtl/pcie_cfg_mgmt_bridge_if.sv
// Signal bundle between the register block, the config bridge and the PCIe endpoint
// config-management port. The bridge uses the slave view; the environment uses the master view.
interface pcie_cfg_mgmt_bridge_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [9:0]  i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_wstrb;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic        i_resp_ready;
    logic [9:0]  o_cfg_addr;
    logic [31:0] o_cfg_wdata;
    logic [3:0]  o_cfg_byte_en;
    logic        o_cfg_read;
    logic        o_cfg_write;
    logic [31:0] i_cfg_rdata;
    logic        i_cfg_done;

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_wstrb,
        input  i_resp_ready, i_cfg_rdata, i_cfg_done,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
        output o_cfg_addr, o_cfg_wdata, o_cfg_byte_en, o_cfg_read, o_cfg_write
    );

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_wstrb,
        output i_resp_ready, i_cfg_rdata, i_cfg_done,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
        input  o_cfg_addr, o_cfg_wdata, o_cfg_byte_en, o_cfg_read, o_cfg_write
    );
endinterface

// File: rtl/pcie_cfg_mgmt_bridge.sv
// Bridges single register-block requests onto the PCIe endpoint config-management port,
// with address range rejection, zero-strobe write short-circuit and a completion timeout.
module pcie_cfg_mgmt_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned MAX_DWORD      = 1024
) (
    input logic                   i_clk,
    input logic                   i_rst,
    pcie_cfg_mgmt_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             write_q;
    logic             req_ready;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic             cfg_read;
    logic             cfg_write;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            write_q    <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cfg_read   <= 1'b0;
            cfg_write  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req_valid && req_ready) begin
                        addr_q    <= bus.i_req_addr;
                        wdata_q   <= bus.i_req_wdata;
                        write_q   <= bus.i_req_write;
                        be_q      <= bus.i_req_write ? bus.i_req_wstrb : 4'hF;
                        req_ready <= 1'b0;
                        if (32'(bus.i_req_addr) >= MAX_DWORD) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'hFFFF_FFFF;
                            resp_err   <= 1'b1;
                        end else if (bus.i_req_write && (bus.i_req_wstrb == 4'h0)) begin
                            // Nothing to write: answer immediately without touching the endpoint.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b0;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= '0;
                            cfg_read  <= ~bus.i_req_write;
                            cfg_write <= bus.i_req_write;
                        end
                    end
                end
                ACCESS: begin
                    // Completion wins over timeout when both land in the same cycle.
                    if (bus.i_cfg_done) begin
                        state      <= RESP;
                        cfg_read   <= 1'b0;
                        cfg_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= write_q ? 32'h0 : bus.i_cfg_rdata;
                        resp_err   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        cfg_read   <= 1'b0;
                        cfg_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'hFFFF_FFFF;
                        resp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.i_resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_req_ready   = req_ready;
    assign bus.o_resp_valid  = resp_valid;
    assign bus.o_resp_rdata  = resp_rdata;
    assign bus.o_resp_err    = resp_err;
    assign bus.o_cfg_addr    = addr_q;
    assign bus.o_cfg_wdata   = wdata_q;
    assign bus.o_cfg_byte_en = be_q;
    assign bus.o_cfg_read    = cfg_read;
    assign bus.o_cfg_write   = cfg_write;
endmodule

// File: tb/tb_pcie_cfg_mgmt_bridge.sv
// Randomized bench for pcie_cfg_mgmt_bridge: directed corner cases followed by random
// transactions, all responses predicted by a transaction-level model.
module tb_pcie_cfg_mgmt_bridge;
    localparam int unsigned T    = 256;
    localparam int unsigned MAXD = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcie_cfg_mgmt_bridge_if bus();

    pcie_cfg_mgmt_bridge #(.TIMEOUT_CYCLES(T), .MAX_DWORD(MAXD)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          strobe;
    } exp_t;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // done_at: ACCESS cycle (1-based) on which the endpoint completes; 0 = never.
    function automatic exp_t model(logic wr, logic [9:0] addr, logic [3:0] strb,
                                   int done_at, logic [31:0] cfg_rd);
        exp_t e;
        if (32'(addr) >= MAXD) begin
            e.err = 1'b1; e.rdata = 32'hFFFF_FFFF; e.strobe = 0;
        end else if (wr && strb == 4'h0) begin
            e.err = 1'b0; e.rdata = 32'h0; e.strobe = 0;
        end else if (done_at >= 1 && done_at <= int'(T)) begin
            e.err = 1'b0; e.rdata = wr ? 32'h0 : cfg_rd; e.strobe = done_at;
        end else begin
            e.err = 1'b1; e.rdata = 32'hFFFF_FFFF; e.strobe = int'(T);
        end
        return e;
    endfunction

    task automatic check_reset_outputs();
        check("rst_req_ready",  32'(bus.o_req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.o_resp_valid), 32'd0);
        check("rst_resp_rdata", bus.o_resp_rdata, 32'd0);
        check("rst_resp_err",   32'(bus.o_resp_err), 32'd0);
        check("rst_cfg_read",   32'(bus.o_cfg_read), 32'd0);
        check("rst_cfg_write",  32'(bus.o_cfg_write), 32'd0);
        check("rst_cfg_addr",   32'(bus.o_cfg_addr), 32'd0);
        check("rst_cfg_wdata",  bus.o_cfg_wdata, 32'd0);
        check("rst_cfg_be",     32'(bus.o_cfg_byte_en), 32'd0);
    endtask

    task automatic do_txn(logic wr, logic [9:0] addr, logic [31:0] wdata, logic [3:0] strb,
                          int done_at, logic [31:0] cfg_rd, int hold);
        exp_t       e;
        int         strobes;
        int         waited;
        logic [3:0] exp_be;
        e       = model(wr, addr, strb, done_at, cfg_rd);
        strobes = 0;
        waited  = 0;
        exp_be  = wr ? strb : 4'hF;

        check("req_ready_idle", 32'(bus.o_req_ready), 32'd1);
        bus.i_req_valid = 1'b1;
        bus.i_req_write = wr;
        bus.i_req_addr  = addr;
        bus.i_req_wdata = wdata;
        bus.i_req_wstrb = strb;
        tick();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = 10'($urandom);
        bus.i_req_wdata = $urandom;
        bus.i_req_wstrb = 4'($urandom);

        while (!bus.o_resp_valid && waited < int'(T) + 8) begin
            if (bus.o_cfg_read || bus.o_cfg_write) begin
                strobes++;
                check("cfg_read",  32'(bus.o_cfg_read), 32'(!wr));
                check("cfg_write", 32'(bus.o_cfg_write), 32'(wr));
                check("cfg_addr",  32'(bus.o_cfg_addr), 32'(addr));
                check("cfg_be",    32'(bus.o_cfg_byte_en), 32'(exp_be));
                if (wr) check("cfg_wdata", bus.o_cfg_wdata, wdata);
            end
            check("req_ready_busy", 32'(bus.o_req_ready), 32'd0);
            bus.i_cfg_done  = (strobes > 0) && (strobes == done_at);
            bus.i_cfg_rdata = bus.i_cfg_done ? cfg_rd : $urandom;
            tick();
            waited++;
        end
        bus.i_cfg_done = 1'b0;

        check("resp_valid",    32'(bus.o_resp_valid), 32'd1);
        check("strobe_cycles", 32'(strobes), 32'(e.strobe));
        check("latency",       32'(waited), 32'(e.strobe));
        check("resp_rdata",    bus.o_resp_rdata, e.rdata);
        check("resp_err",      32'(bus.o_resp_err), 32'(e.err));
        check("strobe_off",    32'({bus.o_cfg_read, bus.o_cfg_write}), 32'd0);

        // Back-pressure: stray completions and new requests must not disturb the response.
        for (int i = 0; i < hold; i++) begin
            bus.i_cfg_done  = 1'b1;
            bus.i_cfg_rdata = $urandom;
            bus.i_req_valid = 1'b1;
            tick();
            check("hold_valid", 32'(bus.o_resp_valid), 32'd1);
            check("hold_rdata", bus.o_resp_rdata, e.rdata);
            check("hold_err",   32'(bus.o_resp_err), 32'(e.err));
            check("hold_ready", 32'(bus.o_req_ready), 32'd0);
            check("hold_strobe", 32'({bus.o_cfg_read, bus.o_cfg_write}), 32'd0);
        end
        bus.i_cfg_done   = 1'b0;
        bus.i_resp_ready = 1'b1;
        tick();
        bus.i_resp_ready = 1'b0;
        bus.i_req_valid  = 1'b0;
        check("resp_done",   32'(bus.o_resp_valid), 32'd0);
        check("ready_again", 32'(bus.o_req_ready), 32'd1);
    endtask

    task automatic stray_done_idle();
        bus.i_cfg_done  = 1'b1;
        bus.i_cfg_rdata = $urandom;
        tick();
        bus.i_cfg_done = 1'b0;
        check("stray_valid",  32'(bus.o_resp_valid), 32'd0);
        check("stray_strobe", 32'({bus.o_cfg_read, bus.o_cfg_write}), 32'd0);
        check("stray_ready",  32'(bus.o_req_ready), 32'd1);
    endtask

    initial begin
        bus.i_req_valid  = 1'b0;
        bus.i_req_write  = 1'b0;
        bus.i_req_addr   = '0;
        bus.i_req_wdata  = '0;
        bus.i_req_wstrb  = '0;
        bus.i_resp_ready = 1'b0;
        bus.i_cfg_rdata  = '0;
        bus.i_cfg_done   = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs();

        do_txn(1'b0, 10'h004, 32'h0, 4'h0, 3, 32'h10EE_7024, 0);
        do_txn(1'b1, 10'h001, 32'h0000_0006, 4'h3, 1, 32'h0, 0);
        do_txn(1'b0, 10'h008, 32'h0, 4'h0, 0, 32'h0, 1);
        stray_done_idle();
        do_txn(1'b0, 10'h3FF, 32'h0, 4'h0, 1, 32'h1234_5678, 0);
        do_txn(1'b1, 10'h010, 32'hDEAD_BEEF, 4'h0, 1, 32'h0, 0);
        do_txn(1'b0, 10'h020, 32'h0, 4'h0, 256, 32'hCAFE_F00D, 0);
        do_txn(1'b1, 10'h1FF, 32'hA5A5_A5A5, 4'hF, 2, 32'h0, 5);

        // Reset in the middle of an access must drop the transaction silently.
        bus.i_req_valid = 1'b1;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = 10'h004;
        tick();
        bus.i_req_valid = 1'b0;
        tick();
        check("pre_rst_read", 32'(bus.o_cfg_read), 32'd1);
        rst = 1'b1;
        bus.i_cfg_done  = 1'b1;
        bus.i_cfg_rdata = 32'h5555_AAAA;
        tick();
        rst = 1'b0;
        bus.i_cfg_done = 1'b0;
        check_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_resp", 32'(bus.o_resp_valid), 32'd0);
        end

        for (int n = 0; n < 150; n++) begin
            logic        wr;
            logic [9:0]  addr;
            logic [3:0]  strb;
            int          sel;
            int          done_at;
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(512, 1023))
                                               : 10'($urandom_range(0, 511));
            strb = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            sel  = int'($urandom_range(0, 29));
            if (sel == 0)      done_at = 0;
            else if (sel == 1) done_at = 256;
            else if (sel == 2) done_at = 257;
            else               done_at = int'($urandom_range(1, 6));
            do_txn(wr, addr, $urandom, strb, done_at, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) stray_done_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
